// File: rtl/control_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes,
// FSM states, instruction classes and small decode helpers.
package control_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // E0..E5 must stay consecutive: the FSM advances through them by +1.
  typedef enum logic [3:0] {
    S_RST, S_F0, S_FW, S_F1, S_F2,
    S_E0, S_E1, S_E2, S_E3, S_E4, S_E5,
    S_MW, S_STOP, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_IMM, CL_MULDIV, CL_NEGNOT, CL_LDI, CL_LD, CL_ST, CL_BR,
    CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } op_class_t;

  function automatic bit mem_wait_ok(input int w);
    return (w >= 0) && (w <= 3);
  endfunction

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:     return CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:          return CL_IMM;
      OP_MUL, OP_DIV:                    return CL_MULDIV;
      OP_NEG, OP_NOT:                    return CL_NEGNOT;
      OP_LDI:                            return CL_LDI;
      OP_LD:                             return CL_LD;
      OP_ST:                             return CL_ST;
      OP_BR:                             return CL_BR;
      OP_JR:                             return CL_JR;
      OP_IN:                             return CL_IN;
      OP_OUT:                            return CL_OUT;
      OP_MFHI:                           return CL_MFHI;
      OP_MFLO:                           return CL_MFLO;
      OP_HALT:                           return CL_HALT;
      OP_JAL, OP_NOP:                    return CL_NOP;
      default:                           return CL_NOP;
    endcase
  endfunction

  // Index of the final execute step for each class (E0 = 0).
  function automatic logic [2:0] last_step(input op_class_t cl);
    case (cl)
      CL_ALU, CL_IMM, CL_LDI:  return 3'd2;
      CL_MULDIV, CL_BR:        return 3'd3;
      CL_NEGNOT:               return 3'd1;
      CL_LD, CL_ST:            return 3'd4;
      default:                 return 3'd0;
    endcase
  endfunction

  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control unit for the single-bus Mini SRC datapath.
// state | meaning
// RST   | held in reset, all strobes low
// F0    | PC to MAR, increment PC
// FW    | RAM read wait (MEM_WAIT cycles)
// F1    | RAM data into MDR
// F2    | MDR into IR
// E0-E5 | execute steps of the current instruction
// MW    | RAM read wait for ld (MEM_WAIT cycles)
// STOP  | paused at an instruction boundary until Stop falls
// HALT  | halted until Clear
module control_unit
  import control_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        ConFF_Out,
  input  logic        Stop,
  output logic        Run,
  output logic        PC_Out,
  output logic        MDR_Out,
  output logic        ZHI_Out,
  output logic        ZLO_Out,
  output logic        HI_Out,
  output logic        LO_Out,
  output logic        C_Out,
  output logic        InPort_Out,
  output logic        PC_In,
  output logic        MDR_In,
  output logic        MAR_In,
  output logic        IR_In,
  output logic        Y_In,
  output logic        ZHI_In,
  output logic        ZLO_In,
  output logic        HI_In,
  output logic        LO_In,
  output logic        OutPort_In,
  output logic        Con_In,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        G_RA,
  output logic        G_RB,
  output logic        G_RC,
  output logic        R_In,
  output logic        R_Out,
  output logic        BA_Out,
  output logic [4:0]  CONTROL
);

  generate
    if (!mem_wait_ok(MEM_WAIT)) begin : g_mem_wait_range
      $error("control_unit: MEM_WAIT must be within 0..3");
    end
  endgenerate

  localparam logic [1:0] WAIT_LOAD = (MEM_WAIT > 0) ? 2'(MEM_WAIT - 1) : 2'd0;

  state_t     state, state_nxt, boundary;
  logic [1:0] cnt, cnt_nxt;
  logic [4:0] op;
  op_class_t  cls;
  logic [2:0] step, last;
  logic       unused_ir;

  assign op   = IR[31:27];
  assign cls  = op_class(op);
  assign last = last_step(cls);
  // Register fields are decoded by the datapath's select/encode logic.
  assign unused_ir = ^IR[26:0];
  assign boundary  = Stop ? S_STOP : S_F0;

  always_comb begin
    step = 3'd0;
    case (state)
      S_E1:    step = 3'd1;
      S_E2:    step = 3'd2;
      S_E3:    step = 3'd3;
      S_E4:    step = 3'd4;
      S_E5:    step = 3'd5;
      default: step = 3'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_RST:  state_nxt = boundary;
      S_F0: begin
        if (MEM_WAIT == 0) begin
          state_nxt = S_F1;
        end else begin
          state_nxt = S_FW;
          cnt_nxt   = WAIT_LOAD;
        end
      end
      S_FW: begin
        if (cnt == 2'd0) state_nxt = S_F1;
        else             cnt_nxt   = cnt - 2'd1;
      end
      S_F1:   state_nxt = S_F2;
      S_F2:   state_nxt = S_E0;
      S_MW: begin
        if (cnt == 2'd0) state_nxt = S_E3;
        else             cnt_nxt   = cnt - 2'd1;
      end
      S_STOP: if (!Stop) state_nxt = S_F0;
      S_HALT: state_nxt = S_HALT;
      default: begin
        if (cls == CL_HALT) begin
          state_nxt = S_HALT;
        end else if (cls == CL_LD && state == S_E2) begin
          if (MEM_WAIT == 0) begin
            state_nxt = S_E3;
          end else begin
            state_nxt = S_MW;
            cnt_nxt   = WAIT_LOAD;
          end
        end else if (step >= last) begin
          state_nxt = boundary;
        end else begin
          state_nxt = state_t'(state + 4'd1);
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= S_RST;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    Run = 1'b0;
    PC_Out = 1'b0; MDR_Out = 1'b0; ZHI_Out = 1'b0; ZLO_Out = 1'b0;
    HI_Out = 1'b0; LO_Out = 1'b0; C_Out = 1'b0; InPort_Out = 1'b0;
    PC_In = 1'b0; MDR_In = 1'b0; MAR_In = 1'b0; IR_In = 1'b0; Y_In = 1'b0;
    ZHI_In = 1'b0; ZLO_In = 1'b0; HI_In = 1'b0; LO_In = 1'b0;
    OutPort_In = 1'b0; Con_In = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    G_RA = 1'b0; G_RB = 1'b0; G_RC = 1'b0; R_In = 1'b0; R_Out = 1'b0;
    BA_Out = 1'b0;
    CONTROL = 5'd0;
    case (state)
      S_RST, S_STOP, S_HALT: Run = 1'b0;
      S_F0: begin Run = 1'b1; PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1; end
      S_FW, S_MW: begin Run = 1'b1; Read = 1'b1; end
      S_F1: begin Run = 1'b1; Read = 1'b1; MDR_In = 1'b1; end
      S_F2: begin Run = 1'b1; MDR_Out = 1'b1; IR_In = 1'b1; end
      default: begin
        Run = 1'b1;
        case (cls)
          CL_ALU, CL_IMM: begin
            case (step)
              3'd0: begin G_RB = 1'b1; R_Out = 1'b1; Y_In = 1'b1; end
              3'd1: begin
                ZLO_In = 1'b1;
                if (cls == CL_ALU) begin
                  G_RC = 1'b1; R_Out = 1'b1; ZHI_In = 1'b1; CONTROL = op;
                end else begin
                  C_Out = 1'b1; CONTROL = imm_alu_op(op);
                end
              end
              3'd2: begin ZLO_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
              default: ;
            endcase
          end
          CL_MULDIV: begin
            case (step)
              3'd0: begin G_RA = 1'b1; R_Out = 1'b1; Y_In = 1'b1; end
              3'd1: begin
                G_RB = 1'b1; R_Out = 1'b1; CONTROL = op;
                ZHI_In = 1'b1; ZLO_In = 1'b1;
              end
              3'd2: begin ZLO_Out = 1'b1; LO_In = 1'b1; end
              3'd3: begin ZHI_Out = 1'b1; HI_In = 1'b1; end
              default: ;
            endcase
          end
          CL_NEGNOT: begin
            case (step)
              3'd0: begin G_RB = 1'b1; R_Out = 1'b1; CONTROL = op; ZLO_In = 1'b1; end
              3'd1: begin ZLO_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
              default: ;
            endcase
          end
          CL_LDI, CL_LD, CL_ST: begin
            // Effective address (or immediate) is formed as BA(Rb) + C.
            case (step)
              3'd0: begin G_RB = 1'b1; BA_Out = 1'b1; Y_In = 1'b1; end
              3'd1: begin C_Out = 1'b1; CONTROL = OP_ADD; ZLO_In = 1'b1; end
              3'd2: begin
                ZLO_Out = 1'b1;
                if (cls == CL_LDI) begin G_RA = 1'b1; R_In = 1'b1; end
                else               MAR_In = 1'b1;
              end
              3'd3: begin
                MDR_In = 1'b1;
                if (cls == CL_LD) Read = 1'b1;
                else begin G_RA = 1'b1; R_Out = 1'b1; end
              end
              3'd4: begin
                if (cls == CL_LD) begin MDR_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
                else              Write = 1'b1;
              end
              default: ;
            endcase
          end
          CL_BR: begin
            case (step)
              3'd0: begin G_RA = 1'b1; R_Out = 1'b1; Con_In = 1'b1; end
              3'd1: begin PC_Out = 1'b1; Y_In = 1'b1; end
              3'd2: begin C_Out = 1'b1; CONTROL = OP_ADD; ZLO_In = 1'b1; end
              3'd3: if (ConFF_Out) begin ZLO_Out = 1'b1; PC_In = 1'b1; end
              default: ;
            endcase
          end
          CL_JR:   if (step == 3'd0) begin G_RA = 1'b1; R_Out = 1'b1; PC_In = 1'b1; end
          CL_IN:   if (step == 3'd0) begin InPort_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
          CL_OUT:  if (step == 3'd0) begin G_RA = 1'b1; R_Out = 1'b1; OutPort_In = 1'b1; end
          CL_MFHI: if (step == 3'd0) begin HI_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
          CL_MFLO: if (step == 3'd0) begin LO_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore-style control unit sequencing the single-bus Mini SRC datapath. It drives every bus-drive, register-load, ALU, memory and select/encode strobe needed to fetch and execute one instruction at a time, reading only the IR contents and the ConFF branch flag back from the datapath. It sits beside the datapath at CPU top level; the datapath needs no logic changes beyond exporting `IR`.

## Interface
- `MEM_WAIT`, 1: number of Read-only wait cycles before each `MDR_In` (RAM has a registered output); legal range 0–3.
- `Clock` in 1: single system clock; all state changes on the rising edge.
- `Clear` in 1: asynchronous, active-low reset.
- `IR` in 32: instruction register contents; opcode is `IR[31:27]`.
- `ConFF_Out` in 1: branch condition from ConFF.
- `Stop` in 1: pause request, sampled only at instruction boundaries.
- `Run` out 1: high while executing; low in reset, STOP and HALT.
- `PC_Out`, `MDR_Out`, `ZHI_Out`, `ZLO_Out`, `HI_Out`, `LO_Out`, `C_Out`, `InPort_Out` out 1 each: bus-drive selects.
- `PC_In`, `MDR_In`, `MAR_In`, `IR_In`, `Y_In`, `ZHI_In`, `ZLO_In`, `HI_In`, `LO_In`, `OutPort_In`, `Con_In` out 1 each: register loads.
- `IncPC`, `Read`, `Write` out 1 each: PC increment and RAM strobes.
- `G_RA`, `G_RB`, `G_RC`, `R_In`, `R_Out`, `BA_Out` out 1 each: select/encode controls.
- `CONTROL` out 5: ALU operation. The ALU code equals the opcode. ADD (00011) is used for address and offset arithmetic.

## Operation
- States:
  - Reset and fetch: RST, F0, FW, F1, F2.
  - Execute: E0–E5.
  - Memory wait and pause: MW, STOP, HALT.
- An internal 2-bit counter times FW and MW.
- Outputs are a pure function of the state register and `IR`. At most one bus driver is asserted per state.
- RST → F0 on the first edge with `Clear` high.
- F0 (`PC_Out`, `MAR_In`, `IncPC`):
  - Sequence: F0 → FW repeated `MEM_WAIT` times (`Read`) → F1 (`Read`, `MDR_In`) → F2 (`MDR_Out`, `IR_In`) → E0.
  - With `MEM_WAIT` = 0, F0 goes directly to F1.
- Before F0: if `Stop` is high, go to STOP instead. STOP holds with all strobes low and returns to F0 on the edge after `Stop` falls.
- Execute sequences, one state per step; the last step returns to F0 or STOP:
  - add/sub/shr/shl/ror/rol/and/or: E0 `G_RB R_Out Y_In`; E1 `G_RC R_Out CONTROL=op ZLO_In ZHI_In`; E2 `ZLO_Out G_RA R_In`.
  - addi/andi/ori: E0 `G_RB R_Out Y_In`; E1 `C_Out CONTROL=add/and/or ZLO_In`; E2 `ZLO_Out G_RA R_In`.
  - mul/div: E0 `G_RA R_Out Y_In`; E1 `G_RB R_Out CONTROL=op ZHI_In ZLO_In`; E2 `ZLO_Out LO_In`; E3 `ZHI_Out HI_In`.
  - neg/not: E0 `G_RB R_Out CONTROL=op ZLO_In`; E1 `ZLO_Out G_RA R_In`.
  - ldi: E0 `G_RB BA_Out Y_In`; E1 `C_Out ADD ZLO_In`; E2 `ZLO_Out G_RA R_In`.
  - ld: same E0–E1 as ldi; E2 `ZLO_Out MAR_In`; then MW×`MEM_WAIT` (`Read`); E3 `Read MDR_In`; E4 `MDR_Out G_RA R_In`.
  - st: E0–E2 as ld; E3 `G_RA R_Out MDR_In`; E4 `Write`.
  - br: E0 `G_RA R_Out Con_In`; E1 `PC_Out Y_In`; E2 `C_Out ADD ZLO_In`; E3 `ZLO_Out PC_In` only if `ConFF_Out`=1, otherwise no strobes.
  - jr: E0 `G_RA R_Out PC_In`.
  - in: E0 `InPort_Out G_RA R_In`.
  - out: E0 `G_RA R_Out OutPort_In`.
  - mfhi: E0 `HI_Out G_RA R_In`.
  - mflo: E0 `LO_Out G_RA R_In`.
- nop, jal and opcodes 11011–11111 execute as nop: E0 with no strobes.
- halt (11010): HALT is entered from E0. HALT is absorbing (`Run`=0, no strobes) until `Clear` is asserted; `Stop` is ignored in HALT.

## Timing
- During `Clear` low: state is RST immediately (asynchronous), all outputs 0, `CONTROL`=0, `Run`=0, counter 0.
- `Run`=1 in every state except RST, STOP and HALT.
- Reset mid-instruction aborts the instruction at once. Any `Write` or `R_In` pulse that is active ends immediately; no partial sequence resumes. Fetch restarts at F0 one edge after release.
- Instruction lengths, including 4 fetch cycles at `MEM_WAIT`=1:
  - ALU reg-reg and immediate: 7.
  - mul/div: 8.
  - neg/not: 6.
  - ld: 10; ldi: 7; st: 9.
  - br: 8; jr/in/out/mfhi/mflo/nop: 5.
  - Each extra `MEM_WAIT` adds one cycle to fetch and one to ld.
- `IR` is sampled only in E0 and later states. The `IR` value present in F0–F2 is don't-care.
- `Stop` rising mid-instruction takes effect only at the next boundary. `Stop` high at reset release puts the unit in STOP after RST.

## Structure
- Package `control_pkg`: 5-bit opcode constants (ld = 00000 … halt = 11010), the state enumeration, and the `MEM_WAIT` legal-range check.
- Single module. The next-state logic and the output decode are two combinational blocks over one state register plus the wait counter; no sub-module.

## Test plan
- Reset: hold `Clear` low 3 cycles → all outputs 0 and `Run`=0. Release → F0 strobes (`PC_Out`, `MAR_In`, `IncPC`) on the next cycle.
- Fetch and `add` (`IR`=0x19890000, add R3,R1,R2): strobe sequence exactly as specified, `CONTROL`=00011 in E1, back to F0 on cycle 8.
- ld and st: with `MEM_WAIT`=1 and 2, ld takes 10/12 cycles with exactly 2/3 cycles of `Read` in the memory phase; st asserts `Write` for exactly 1 cycle.
- br: `ConFF_Out`=0 → no `PC_In` in E3; `ConFF_Out`=1 → `ZLO_Out` and `PC_In` in E3.
- Stop and halt:
  - Raise `Stop` during E1 of mul → the instruction completes (8 cycles), then STOP with `Run`=0; lowering `Stop` → F0 one edge later.
  - halt → HALT persists for 20 cycles regardless of `Stop`.
- Reset mid-st: assert `Clear` during E4 → `Write` drops asynchronously; the next instruction starts from F0.
